// File: rtl/bus_responder.sv
// bus_responder: memory-mapped byte RAM target for the executer's CPU bus.
// Decodes a 2^ADDR_BITS window at BASE_ADDR, inserts 0..7 wait states and
// completes each transfer with a one-cycle ready pulse on a four-phase
// req/ready handshake. Vector ports are numbered with the highest index as MSB.
module bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hE000,
    parameter int          ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        req,
    input  logic        rnw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [2:0]  waitStates,
    output logic [7:0]  rdata,
    output logic        nRdOE,
    output logic        ready,
    output logic        selected
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [2:0]             count_r;
    logic [2:0]             count_nxt_s;
    logic                   rnw_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [7:0]             wdata_r;
    logic [7:0]             rdata_r;
    logic                   nrdoe_r;
    logic                   ready_r;
    logic                   selected_r;
    logic                   selected_nxt_s;
    logic                   hit_s;
    logic                   accept_s;
    logic                   enter_ack_s;
    logic                   rd_rnw_s;
    logic [ADDR_BITS-1:0]   rd_addr_s;
    logic [7:0]             mem_r [DEPTH];

    // Window decode: only the bits above the RAM index take part.
    assign hit_s = req && (addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

    assign rdata    = rdata_r;
    assign nRdOE    = nrdoe_r;
    assign ready    = ready_r;
    assign selected = selected_r;

    // Next-state, wait counter and selected flag for the transfer sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        selected_nxt_s = selected_r;
        accept_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    accept_s       = 1'b1;
                    selected_nxt_s = 1'b1;
                    if (waitStates == 3'd0) begin
                        state_nxt_s = ACK;
                    end else begin
                        state_nxt_s = WAIT;
                        count_nxt_s = waitStates;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!req) begin
                    // Initiator gave up: drop the transfer without side effects.
                    state_nxt_s    = IDLE;
                    selected_nxt_s = 1'b0;
                    count_nxt_s    = 3'd0;
                end else if (count_r == 3'd1) begin
                    state_nxt_s = ACK;
                    count_nxt_s = 3'd0;
                end else begin
                    count_nxt_s = count_r - 3'd1;
                end
            end
            ACK: begin
                state_nxt_s = RECOVER;
            end
            RECOVER: begin
                selected_nxt_s = 1'b0;
                if (!req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RECOVER;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                count_nxt_s    = 3'd0;
                selected_nxt_s = 1'b0;
            end
        endcase
        // Entering ACK from IDLE uses the live bus; from WAIT the latched copy.
        enter_ack_s = (state_nxt_s == ACK);
        rd_rnw_s    = (state_r == IDLE) ? rnw : rnw_r;
        rd_addr_s   = (state_r == IDLE) ? addr[ADDR_BITS-1:0] : addr_r;
    end

    // Sequencer state and wait counter.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_r <= IDLE;
            count_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Transfer latches and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            rnw_r      <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 8'h00;
            rdata_r    <= 8'h00;
            nrdoe_r    <= 1'b1;
            ready_r    <= 1'b0;
            selected_r <= 1'b0;
        end else begin
            ready_r    <= enter_ack_s;
            nrdoe_r    <= !(enter_ack_s && rd_rnw_s);
            selected_r <= selected_nxt_s;
            if (accept_s) begin
                rnw_r   <= rnw;
                addr_r  <= addr[ADDR_BITS-1:0];
                wdata_r <= wdata;
            end
            if (enter_ack_s && rd_rnw_s) begin
                rdata_r <= mem_r[rd_addr_s];
            end
        end
    end

    // RAM write commits on the edge leaving ACK; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (nReset && (state_r == ACK) && !rnw_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

endmodule
